// File: rtl/draw_pkg.sv
// Shared widths, screen defaults and FSM state encoding for the draw scheduler.
package draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int DIM_W = 4;
  localparam int COL_W = 3;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    ERASE,
    WAIT_E,
    DRAW,
    WAIT_D,
    NEXT,
    FINISH
  } state_t;

endpackage

// File: rtl/sprite_clip.sv
// Clips one sprite rectangle against the right and bottom screen edges.
// A sprite whose origin is off screen, or whose width/height is zero, is
// reported as not visible.
module sprite_clip
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  output logic [DIM_W-1:0] w_eff,
  output logic [DIM_W-1:0] h_eff,
  output logic             visible
);

  logic [8:0] room_w;
  logic [8:0] room_h;

  // Room to the screen edge and the clipped size, at 9 bits so 160-x cannot wrap.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    room_w  = 9'(SCREEN_W) - {1'b0, x};
    room_h  = 9'(SCREEN_H) - {2'b0, y};
    w_eff   = w;
    h_eff   = h;
    visible = ({1'b0, x} < 9'(SCREEN_W)) && ({2'b0, y} < 9'(SCREEN_H)) &&
              (w != '0) && (h != '0);
    if ({5'b0, w} > room_w) w_eff = room_w[DIM_W-1:0];
    if ({5'b0, h} > room_h) h_eff = room_h[DIM_W-1:0];
  end

endmodule

// File: rtl/draw_scheduler.sv
// Frame-level sequencer sharing one rectangle draw engine among N sprites.
// Each frame tick visits every sprite in index order: erase its previous
// rectangle in the background colour, then draw its current one.
// Optional macro DRAW_SCHED_SKIP_STATIC_EN: sprites whose clipped rectangle
// and colour are unchanged since the last draw are skipped entirely.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int               N_SPRITES = 5,
  parameter int               SCREEN_W  = SCREEN_W_DEF,
  parameter int               SCREEN_H  = SCREEN_H_DEF,
  parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [N_SPRITES-1:0]       spr_active,
  input  logic [X_W*N_SPRITES-1:0]   spr_x,
  input  logic [Y_W*N_SPRITES-1:0]   spr_y,
  input  logic [DIM_W*N_SPRITES-1:0] spr_w,
  input  logic [DIM_W*N_SPRITES-1:0] spr_h,
  input  logic [COL_W*N_SPRITES-1:0] spr_c,
  input  logic                       draw_done,
  output logic                       draw_start,
  output logic [X_W-1:0]             draw_x,
  output logic [Y_W-1:0]             draw_y,
  output logic [DIM_W-1:0]           draw_w,
  output logic [DIM_W-1:0]           draw_h,
  output logic [COL_W-1:0]           draw_c,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;

  // Inputs of the sprite currently addressed by idx, and its clipped view.
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [DIM_W-1:0]   sel_w;
  logic [DIM_W-1:0]   sel_h;
  logic [COL_W-1:0]   sel_c;
  logic [DIM_W-1:0]   clip_w;
  logic [DIM_W-1:0]   clip_h;
  logic               clip_vis;
  logic               sel_act;

  // Working copy of the sprite, frozen at SNAP for the rest of its visit.
  logic [X_W-1:0]     cur_x;
  logic [Y_W-1:0]     cur_y;
  logic [DIM_W-1:0]   cur_w;
  logic [DIM_W-1:0]   cur_h;
  logic [COL_W-1:0]   cur_c;
  logic               cur_act;

  // Shadow of what is currently on screen for each sprite.
  logic [X_W-1:0]     old_x [N_SPRITES];
  logic [Y_W-1:0]     old_y [N_SPRITES];
  logic [DIM_W-1:0]   old_w [N_SPRITES];
  logic [DIM_W-1:0]   old_h [N_SPRITES];
  logic [N_SPRITES-1:0] drawn;

  assign sel_x   = spr_x[int'(idx)*X_W +: X_W];
  assign sel_y   = spr_y[int'(idx)*Y_W +: Y_W];
  assign sel_w   = spr_w[int'(idx)*DIM_W +: DIM_W];
  assign sel_h   = spr_h[int'(idx)*DIM_W +: DIM_W];
  assign sel_c   = spr_c[int'(idx)*COL_W +: COL_W];
  assign sel_act = spr_active[idx] && clip_vis;

  sprite_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .x       (sel_x),
    .y       (sel_y),
    .w       (sel_w),
    .h       (sel_h),
    .w_eff   (clip_w),
    .h_eff   (clip_h),
    .visible (clip_vis)
  );

`ifdef DRAW_SCHED_SKIP_STATIC_EN
  logic [COL_W-1:0] old_c [N_SPRITES];
  logic             sel_match;

  assign sel_match = (sel_x == old_x[idx]) && (sel_y == old_y[idx]) &&
                     (clip_w == old_w[idx]) && (clip_h == old_h[idx]) &&
                     (sel_c == old_c[idx]);
`endif

  // Pass sequencer: state, registered engine interface and shadow updates.
  // NOTE: all state here is updated with <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      draw_start <= 1'b0;
      draw_x     <= '0;
      draw_y     <= '0;
      draw_w     <= '0;
      draw_h     <= '0;
      draw_c     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_w      <= '0;
      cur_h      <= '0;
      cur_c      <= '0;
      cur_act    <= 1'b0;
      drawn      <= '0;
      // NOTE: the shadow is reset explicitly; a stale shadow would erase garbage after reset.
      for (int i = 0; i < N_SPRITES; i++) begin
        old_x[i] <= '0;
        old_y[i] <= '0;
        old_w[i] <= '0;
        old_h[i] <= '0;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
        old_c[i] <= '0;
`endif
      end
    end else begin
      draw_start <= 1'b0;
      frame_done <= 1'b0;
      if (frame_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_tick) begin
            state <= SNAP;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end

        SNAP: begin
          cur_x   <= sel_x;
          cur_y   <= sel_y;
          cur_w   <= clip_w;
          cur_h   <= clip_h;
          cur_c   <= sel_c;
          cur_act <= sel_act;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
          if (drawn[idx] && sel_act && sel_match) state <= NEXT;
          else
`endif
          if (drawn[idx]) state <= ERASE;
          else if (sel_act) state <= DRAW;
          else state <= NEXT;
        end

        ERASE: begin
          draw_start <= 1'b1;
          draw_x     <= old_x[idx];
          draw_y     <= old_y[idx];
          draw_w     <= old_w[idx];
          draw_h     <= old_h[idx];
          draw_c     <= BG_COLOUR;
          state      <= WAIT_E;
        end

        WAIT_E: begin
          if (draw_done) begin
            if (cur_act) begin
              state <= DRAW;
            end else begin
              drawn[idx] <= 1'b0;
              state      <= NEXT;
            end
          end
        end

        DRAW: begin
          draw_start <= 1'b1;
          draw_x     <= cur_x;
          draw_y     <= cur_y;
          draw_w     <= cur_w;
          draw_h     <= cur_h;
          draw_c     <= cur_c;
          state      <= WAIT_D;
        end

        WAIT_D: begin
          if (draw_done) begin
            old_x[idx] <= cur_x;
            old_y[idx] <= cur_y;
            old_w[idx] <= cur_w;
            old_h[idx] <= cur_h;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
            old_c[idx] <= cur_c;
`endif
            drawn[idx] <= 1'b1;
            state      <= NEXT;
          end
        end

        NEXT: begin
          if (idx == IDX_W'(N_SPRITES - 1)) begin
            state <= FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= SNAP;
          end
        end

        FINISH: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
Frame-level sequencer that shares the single rectangle draw engine between N sprite requesters (player, enemies, bullets).
- On each frame tick it visits every sprite in index order.
- For each sprite it erases the previously drawn rectangle in the background colour, then draws the sprite's current rectangle.
- Sits between the game-state datapaths and the draw engine, and replaces ad-hoc draw sequencing.

Parameters:
- N_SPRITES, 5, number of requesters (index 0 = player).
- SCREEN_W, 160, pixel columns.
- SCREEN_H, 120, pixel rows.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse; starts a frame pass
- spr_active  in  N_SPRITES  sprite i is visible
- spr_x  in  8*N_SPRITES  packed x, sprite i at [8i+7:8i]
- spr_y  in  7*N_SPRITES  packed y
- spr_w  in  4*N_SPRITES  packed width
- spr_h  in  4*N_SPRITES  packed height
- spr_c  in  3*N_SPRITES  packed colour
- draw_done  in  1  one-cycle pulse from draw engine: rectangle complete
- draw_start  out  1  one-cycle pulse: engine latches draw_x..draw_c
- draw_x  out  8  rectangle origin x
- draw_y  out  7  rectangle origin y
- draw_w  out  4  clipped width
- draw_h  out  4  clipped height
- draw_c  out  3  colour
- busy  out  1  frame pass in progress
- frame_done  out  1  one-cycle pulse at end of pass
- overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset values:
  - all outputs 0.
  - shadow registers (old_x/y/w/h, drawn flag per sprite) cleared.
  - state IDLE; sprite index 0.
- Reset mid-pass: abandons the pass. Any draw_done pulse arriving afterwards is ignored.
- FSM states: IDLE, SNAP, ERASE, WAIT_E, DRAW, WAIT_D, NEXT, FINISH.
- IDLE:
  - frame_tick -> SNAP, busy=1, idx=0.
- SNAP:
  - Latches sprite idx inputs into working registers. Inputs are sampled only here, so mid-pass changes affect the next frame only.
  - If drawn[idx] -> ERASE; else if active -> DRAW; else -> NEXT.
- ERASE:
  - Drives old_x/y/w/h with BG_COLOUR; draw_start=1 for one cycle; -> WAIT_E.
- WAIT_E:
  - Holds outputs stable until draw_done.
  - Then: if active -> DRAW, else clear drawn[idx] and go to NEXT.
- DRAW:
  - Drives latched rect and colour; draw_start=1 for one cycle; -> WAIT_D.
- WAIT_D:
  - On draw_done, copy the latched (clipped) rect to shadow, set drawn[idx], -> NEXT.
- NEXT:
  - If idx==N_SPRITES-1 -> FINISH, else idx+1 -> SNAP.
- FINISH:
  - frame_done=1 for one cycle; busy=0; -> IDLE.
- Clipping, applied at SNAP:
  - x>=SCREEN_W or y>=SCREEN_H: treat the sprite as inactive for this frame.
  - Otherwise w_eff = min(w, SCREEN_W-x) and h_eff = min(h, SCREEN_H-y), computed at 9-bit width.
  - w==0 or h==0: treated as inactive.
- frame_tick while busy: ignored and sets overrun. overrun clears only on reset.
- frame_tick in FINISH: ignored and sets overrun. frame_tick in IDLE is accepted.
- draw_done outside WAIT_E/WAIT_D: ignored.
- draw_done in the same cycle as draw_start: not possible by engine contract. The bench asserts this never happens.
- Minimum pass latency:
  - Per sprite 5 cycles plus engine time for each erase/draw, plus 1 for FINISH.
  - Engine latency unbounded; no timeout.

Optional Feature:
- Macro: DRAW_SCHED_SKIP_STATIC_EN.
- Defined: in SNAP, if drawn[idx] and active and the clipped x/y/w/h and colour all equal the shadow, skip both ERASE and DRAW and go to NEXT. This needs a shadow colour register.
- Undefined: every drawn sprite is always erased and redrawn each frame. There is no colour shadow.

Decomposition:
- Package draw_pkg holds:
  - width constants X_W=8, Y_W=7, DIM_W=4, COL_W=3.
  - SCREEN_W/H defaults.
  - FSM state enum.
- Sub-module sprite_clip (combinational, inside the block): x, y, w, h -> w_eff, h_eff, visible.
- Shadow registers stay in the top.

Test Plan:
- One sprite, x=10, y=20, w=h=10, c=7; tick; engine acks after 3 cycles -> one draw_start with (10,20,10,10,7), no erase, frame_done, busy low.
- Same sprite moved to x=12, second tick -> erase (10,20,10,10,0), then draw (12,20,10,10,7), in that order.
- Sprite 2 goes inactive after being drawn -> erase only; third tick issues no request for sprite 2.
- Sprite at x=155, w=10 -> draw_w=5; sprite at x=170 -> no request.
- frame_tick while busy -> ignored, overrun=1 sticky; reset mid-WAIT_D followed by a stray draw_done -> stays IDLE with all outputs 0.
- With DRAW_SCHED_SKIP_STATIC_EN defined, unchanged sprite on second tick -> zero draw_start pulses, frame_done still pulses.
